// File: rtl/btn_pkg.sv
// Purpose: shared direction codes, FSM state encoding and the direction encoder
//          for the button step generator.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package btn_pkg;

  localparam logic [3:0] BTN_U    = 4'b1000;
  localparam logic [3:0] BTN_D    = 4'b0100;
  localparam logic [3:0] BTN_R    = 4'b0010;
  localparam logic [3:0] BTN_L    = 4'b0001;
  localparam logic [3:0] BTN_NONE = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_DELAY  = 2'd2,
    ST_REPEAT = 2'd3
  } btn_state_e;

  // Only a single pressed direction is meaningful; chords and idle map to none.
  function automatic logic [3:0] btn_encode(input logic [3:0] vec);
    case (vec)
      BTN_U, BTN_D, BTN_R, BTN_L: return vec;
      default:                    return BTN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Purpose: 2-flop synchronizer plus whole-vector debounce of four raw buttons.
// Latency: raw change sampled at edge 0 appears on stable_o after edge DEBOUNCE_CYCLES+1.
// Backpressure: none; free-running.
// Ports: clk, rst (async active-high), raw_i[3:0] (asynchronous buttons),
//        stable_o[3:0] (debounced vector).
module btn_debounce
  import btn_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] raw_i,
  output logic [3:0] stable_o
);

  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [3:0]  stable_q, stable_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_last;

  assign cnt_last = DEBOUNCE_CYCLES - 16'd1;

  always_comb begin
    sync1_d  = raw_i;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    // sync1_q is the next sample of sync2_q, so comparing the two detects a
    // change one cycle earlier than keeping a separate previous-sample flop.
    if (sync1_q != sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q == cnt_last) begin
      stable_d = sync2_q;           // counter saturates here
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= BTN_NONE;
      sync2_q  <= BTN_NONE;
      stable_q <= BTN_NONE;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/btn_step_gen.sv
// Purpose: debounced one-hot direction code plus one-cycle step strobe per press
//          (and auto-repeat while held when BTN_AUTOREPEAT_EN is defined).
// Latency: raw press at edge 0 -> btns_o after edge DEBOUNCE_CYCLES+2 -> step_o after edge DEBOUNCE_CYCLES+3.
// Backpressure: none; step_o is a fire-and-forget strobe.
// Ports: clk, rst (async active-high), btn_raw[3:0] {U,D,R,L} raw pins,
//        btns_o[3:0] registered direction code, step_o step strobe,
//        held_o a single direction is currently held.
// Macro: BTN_AUTOREPEAT_EN enables the delay/repeat stepping; without it one
//        step is issued per press or per direction change.
module btn_step_gen
  import btn_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000,
  parameter int          CNT_W           = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btns_o,
  output logic       step_o,
  output logic       held_o
);

  logic [3:0] deb_vec;
  logic [3:0] code;
  btn_state_e state_q, state_d;
  logic [3:0] btns_q, btns_d;
  logic       step_q, step_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 24'd1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 24'd1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_last;
`endif

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (btn_raw),
    .stable_o (deb_vec)
  );

  assign code = btn_encode(deb_vec);

`ifdef BTN_AUTOREPEAT_EN
  assign cnt_last = (state_q == ST_DELAY) ? DELAY_LAST : PERIOD_LAST;
`endif

  always_comb begin
    state_d = state_q;
    btns_d  = btns_q;
    step_d  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Latches a new direction, or clears btns_o one cycle after release.
        btns_d = code;
        if (code != BTN_NONE) state_d = ST_ARM;
      end
      ST_ARM: begin
        // btns_o was updated last cycle, so it is settled while step_o is high.
        step_d  = 1'b1;
        state_d = ST_DELAY;
`ifdef BTN_AUTOREPEAT_EN
        cnt_d   = '0;
`endif
      end
      ST_DELAY, ST_REPEAT: begin
        if (code == BTN_NONE) begin
          state_d = ST_IDLE;
        end else if (code != btns_q) begin
          btns_d  = code;
          state_d = ST_ARM;
`ifdef BTN_AUTOREPEAT_EN
        end else if (cnt_q == cnt_last) begin
          step_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      btns_q  <= BTN_NONE;
      step_q  <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      btns_q  <= btns_d;
      step_q  <= step_d;
`ifdef BTN_AUTOREPEAT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign btns_o = btns_q;
  assign step_o = step_q;
  assign held_o = (state_q != ST_IDLE);

endmodule
